// File: rtl/uart_frame_loader.sv
// UART frame loader: receives 8N1 bytes on rx, decodes A5/type/payload frames and
// writes kernel coefficients or image pixels into their BRAM write ports.
module uart_frame_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned KERNEL_SIZE  = 9,
  parameter int unsigned IMAGE_SIZE   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        kernel_we,
  output logic [3:0]  kernel_addr,
  output logic [7:0]  kernel_wdata,
  output logic        image_we,
  output logic [15:0] image_addr,
  output logic [7:0]  image_wdata,
  output logic        kernel_loaded,
  output logic        image_loaded,
  output logic        frame_error,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] KernelLast = 16'(KERNEL_SIZE - 1);
  localparam logic [15:0] ImageLast  = 16'(IMAGE_SIZE - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {FrWaitSync, FrWaitType, FrPayload} fr_state_e;

  // ---------------------------------------------------------------------------
  // rx synchronizer; rx_prev_q lets the receiver see a falling edge
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Two-flop synchronizer plus one delayed copy for edge detection, idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit receiver
  // ---------------------------------------------------------------------------
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done;
  logic            stop_err;
  logic            byte_valid_q;

  // Receiver next state: mid-bit sampling driven by a per-bit cycle counter.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    stop_err   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          cnt_d      = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d      = '0;
          bit_d      = '0;
          // Line back high at mid start bit means a glitch, not a character.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d      = '0;
          rx_state_d = RxIdle;
          if (rx_sync_q) begin
            byte_done = 1'b1;
          end else begin
            stop_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Receiver state registers; byte_valid_q pulses one cycle after the stop sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RxIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------------------
  fr_state_e   fr_state_q, fr_state_d;
  logic        is_image_q, is_image_d;
  logic [15:0] count_q, count_d;
  logic        kernel_loaded_q, kernel_loaded_d;
  logic        image_loaded_q, image_loaded_d;
  logic        kernel_done_q, kernel_done_d;
  logic        image_done_q, image_done_d;
  logic        kernel_we_q, kernel_we_d;
  logic [3:0]  kernel_addr_q, kernel_addr_d;
  logic [7:0]  kernel_wdata_q, kernel_wdata_d;
  logic        image_we_q, image_we_d;
  logic [15:0] image_addr_q, image_addr_d;
  logic [7:0]  image_wdata_q, image_wdata_d;
  logic        frame_error_q, frame_error_d;

  // Frame next state: advances on each received byte, a bad stop bit aborts.
  always_comb begin
    fr_state_d      = fr_state_q;
    is_image_d      = is_image_q;
    count_d         = count_q;
    // Loaded flags rise the cycle after the final write strobe.
    kernel_loaded_d = kernel_loaded_q | kernel_done_q;
    image_loaded_d  = image_loaded_q | image_done_q;
    kernel_done_d   = 1'b0;
    image_done_d    = 1'b0;
    kernel_we_d     = 1'b0;
    kernel_addr_d   = kernel_addr_q;
    kernel_wdata_d  = kernel_wdata_q;
    image_we_d      = 1'b0;
    image_addr_d    = image_addr_q;
    image_wdata_d   = image_wdata_q;
    frame_error_d   = stop_err;
    if (stop_err) begin
      fr_state_d = FrWaitSync;
    end else if (byte_valid_q) begin
      unique case (fr_state_q)
        FrWaitSync: begin
          if (shift_q == 8'hA5) fr_state_d = FrWaitType;
        end
        FrWaitType: begin
          count_d = '0;
          if (shift_q == 8'h01) begin
            is_image_d      = 1'b0;
            kernel_loaded_d = 1'b0;
            fr_state_d      = FrPayload;
          end else if (shift_q == 8'h02) begin
            is_image_d     = 1'b1;
            image_loaded_d = 1'b0;
            fr_state_d     = FrPayload;
          end else begin
            frame_error_d = 1'b1;
            fr_state_d    = FrWaitSync;
          end
        end
        FrPayload: begin
          // Payload bytes are never inspected for sync; 0xA5 is ordinary data here.
          count_d = count_q + 16'd1;
          if (is_image_q) begin
            image_we_d    = 1'b1;
            image_addr_d  = count_q;
            image_wdata_d = shift_q;
            if (count_q == ImageLast) begin
              image_done_d = 1'b1;
              fr_state_d   = FrWaitSync;
            end
          end else begin
            kernel_we_d    = 1'b1;
            kernel_addr_d  = count_q[3:0];
            kernel_wdata_d = shift_q;
            if (count_q == KernelLast) begin
              kernel_done_d = 1'b1;
              fr_state_d    = FrWaitSync;
            end
          end
        end
        default: fr_state_d = FrWaitSync;
      endcase
    end
  end

  // Frame state and registered BRAM-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fr_state_q      <= FrWaitSync;
      is_image_q      <= 1'b0;
      count_q         <= '0;
      kernel_loaded_q <= 1'b0;
      image_loaded_q  <= 1'b0;
      kernel_done_q   <= 1'b0;
      image_done_q    <= 1'b0;
      kernel_we_q     <= 1'b0;
      kernel_addr_q   <= '0;
      kernel_wdata_q  <= '0;
      image_we_q      <= 1'b0;
      image_addr_q    <= '0;
      image_wdata_q   <= '0;
      frame_error_q   <= 1'b0;
    end else begin
      fr_state_q      <= fr_state_d;
      is_image_q      <= is_image_d;
      count_q         <= count_d;
      kernel_loaded_q <= kernel_loaded_d;
      image_loaded_q  <= image_loaded_d;
      kernel_done_q   <= kernel_done_d;
      image_done_q    <= image_done_d;
      kernel_we_q     <= kernel_we_d;
      kernel_addr_q   <= kernel_addr_d;
      kernel_wdata_q  <= kernel_wdata_d;
      image_we_q      <= image_we_d;
      image_addr_q    <= image_addr_d;
      image_wdata_q   <= image_wdata_d;
      frame_error_q   <= frame_error_d;
    end
  end

  assign kernel_we     = kernel_we_q;
  assign kernel_addr   = kernel_addr_q;
  assign kernel_wdata  = kernel_wdata_q;
  assign image_we      = image_we_q;
  assign image_addr    = image_addr_q;
  assign image_wdata   = image_wdata_q;
  assign kernel_loaded = kernel_loaded_q;
  assign image_loaded  = image_loaded_q;
  assign frame_error   = frame_error_q;
  assign busy          = (fr_state_q != FrWaitSync);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized self-checking bench for uart_frame_loader: frames are built at the
// protocol level and the expected BRAM writes, error pulses and flags are queued.
module tb_uart_frame_loader;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Ks  = 9;
  localparam int unsigned Is  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        kernel_we;
  logic [3:0]  kernel_addr;
  logic [7:0]  kernel_wdata;
  logic        image_we;
  logic [15:0] image_addr;
  logic [7:0]  image_wdata;
  logic        kernel_loaded;
  logic        image_loaded;
  logic        frame_error;
  logic        busy;

  uart_frame_loader #(
    .CLKS_PER_BIT(Cpb),
    .KERNEL_SIZE (Ks),
    .IMAGE_SIZE  (Is)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .kernel_we    (kernel_we),
    .kernel_addr  (kernel_addr),
    .kernel_wdata (kernel_wdata),
    .image_we     (image_we),
    .image_addr   (image_addr),
    .image_wdata  (image_wdata),
    .kernel_loaded(kernel_loaded),
    .image_loaded (image_loaded),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  int   kq_addr[$];
  int   kq_data[$];
  int   iq_addr[$];
  int   iq_data[$];
  int   exp_err = 0;
  int   err_seen = 0;
  bit   exp_kl = 1'b0;
  bit   exp_il = 1'b0;
  int   last_k_addr = -1;
  int   last_k_data = -1;
  int   img_mem[16];
  logic [7:0] payload[16];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Per-cycle compare of the write ports against the expected-write queues.
  initial begin
    int a;
    int d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (kernel_we || image_we) check("we_exclusive", int'(kernel_we && image_we), 0);
        if (kernel_we) begin
          check("kernel_write_expected", int'(kq_addr.size() > 0), 1);
          if (kq_addr.size() > 0) begin
            a = kq_addr.pop_front();
            d = kq_data.pop_front();
            check("kernel_addr", int'(kernel_addr), a);
            check("kernel_wdata", int'(kernel_wdata), d);
          end
          last_k_addr = int'(kernel_addr);
          last_k_data = int'(kernel_wdata);
        end
        if (image_we) begin
          check("image_write_expected", int'(iq_addr.size() > 0), 1);
          if (iq_addr.size() > 0) begin
            a = iq_addr.pop_front();
            d = iq_data.pop_front();
            check("image_addr", int'(image_addr), a);
            check("image_wdata", int'(image_wdata), d);
          end
          img_mem[image_addr[3:0]] = int'(image_wdata);
        end
        if (frame_error) err_seen++;
      end
    end
  end

  initial begin
    #(900000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_bit(input logic v);
    #1 rx = v;
    repeat (Cpb) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(bad_stop ? 1'b0 : 1'b1);
    #1 rx = 1'b1;
    idle($urandom_range(1, 6));
  endtask

  task automatic glitch();
    #1 rx = 1'b0;
    repeat (Cpb / 4) @(posedge clk);
    #1 rx = 1'b1;
    idle(2 * Cpb);
  endtask

  // Type byte plus payload; models writes, error pulses and flag outcome.
  task automatic send_body(input logic [7:0] typ, input int n, input int bad_idx);
    send_byte(typ, 1'b0);
    if (typ != 8'h01 && typ != 8'h02) begin
      exp_err++;
      return;
    end
    if (typ == 8'h01) exp_kl = 1'b0;
    else exp_il = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == bad_idx) begin
        exp_err++;
        send_byte(payload[i], 1'b1);
        return;
      end
      if (typ == 8'h01) begin
        kq_addr.push_back(i);
        kq_data.push_back(int'(payload[i]));
      end else begin
        iq_addr.push_back(i);
        iq_data.push_back(int'(payload[i]));
      end
      send_byte(payload[i], 1'b0);
    end
    if (typ == 8'h01) exp_kl = 1'b1;
    else exp_il = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] typ, input int n, input int bad_idx);
    send_byte(8'hA5, 1'b0);
    send_body(typ, n, bad_idx);
  endtask

  task automatic settle_check(input string tag);
    idle(3 * Cpb);
    #2;
    check({tag, "_errors"}, err_seen, exp_err);
    check({tag, "_kernel_pending"}, kq_addr.size(), 0);
    check({tag, "_image_pending"}, iq_addr.size(), 0);
    check({tag, "_kernel_loaded"}, int'(kernel_loaded), int'(exp_kl));
    check({tag, "_image_loaded"}, int'(image_loaded), int'(exp_il));
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_kernel_we"}, int'(kernel_we), 0);
    check({tag, "_kernel_addr"}, int'(kernel_addr), 0);
    check({tag, "_kernel_wdata"}, int'(kernel_wdata), 0);
    check({tag, "_image_we"}, int'(image_we), 0);
    check({tag, "_image_addr"}, int'(image_addr), 0);
    check({tag, "_image_wdata"}, int'(image_wdata), 0);
    check({tag, "_kernel_loaded"}, int'(kernel_loaded), 0);
    check({tag, "_image_loaded"}, int'(image_loaded), 0);
    check({tag, "_frame_error"}, int'(frame_error), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    logic [7:0] typ;
    logic [7:0] b;
    int n;
    int bad;
    rx    = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) img_mem[i] = -1;
    idle(3);
    #2 check_zero("reset");
    reset = 1'b0;
    idle(5);

    // Kernel frame 01..09
    for (int i = 0; i < 16; i++) payload[i] = 8'(i + 1);
    send_frame(8'h01, Ks, -1);
    settle_check("kernel");
    check("kernel_last_addr", last_k_addr, 8);
    check("kernel_last_data", last_k_data, 9);

    // Image frame 00..0F with A5 embedded at index 5
    for (int i = 0; i < 16; i++) payload[i] = 8'(i);
    payload[5] = 8'hA5;
    send_frame(8'h02, Is, -1);
    settle_check("image");
    check("image_mem0", img_mem[0], 8'h00);
    check("image_mem5", img_mem[5], 8'hA5);
    check("image_mem15", img_mem[15], 8'h0F);

    // Bad stop bit on third kernel payload byte, then a clean kernel frame
    for (int i = 0; i < 16; i++) payload[i] = 8'($urandom);
    send_frame(8'h01, Ks, 2);
    settle_check("bad_stop");
    send_frame(8'h01, Ks, -1);
    settle_check("after_bad_stop");

    // Unknown type, then a kernel frame
    send_frame(8'h07, 0, -1);
    settle_check("unknown_type");
    send_frame(8'h01, Ks, -1);
    settle_check("after_unknown");

    // Glitches: at idle, and while waiting for the type byte
    glitch();
    settle_check("glitch_idle");
    send_byte(8'hA5, 1'b0);
    idle(Cpb);
    #2 check("busy_after_sync", int'(busy), 1);
    glitch();
    #2 check("busy_after_glitch", int'(busy), 1);
    for (int i = 0; i < 16; i++) payload[i] = 8'($urandom);
    send_body(8'h01, Ks, -1);
    settle_check("glitch_type");

    // Reset in the middle of an image frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    exp_il = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iq_addr.push_back(i);
      iq_data.push_back(int'(payload[i]));
      send_byte(payload[i], 1'b0);
    end
    idle(Cpb);
    #2 check("pre_reset_pending", iq_addr.size(), 0);
    #1 rx = 1'b0;
    idle(3 * Cpb);
    #1 reset = 1'b1;
    #1 check_zero("mid_reset");
    rx = 1'b1;
    exp_kl = 1'b0;
    exp_il = 1'b0;
    idle(3);
    #1 reset = 1'b0;
    settle_check("post_reset");
    for (int i = 0; i < 16; i++) img_mem[i] = -1;
    for (int i = 0; i < 16; i++) payload[i] = 8'($urandom);
    send_frame(8'h02, Is, -1);
    settle_check("image_after_reset");
    check("image_after_reset_mem0", img_mem[0], int'(payload[0]));

    // Randomized frames with garbage preambles, bad stops and unknown types
    for (int f = 0; f < 8; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, 1'b0);
      end
      for (int i = 0; i < 16; i++) payload[i] = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) typ = 8'(3 + $urandom_range(0, 200));
      else typ = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      n = (typ == 8'h01) ? Ks : Is;
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      send_frame(typ, n, bad);
      settle_check("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
